memory_page_reader: RTL

//  Read-side master for the paged block-RAM store. On start, drains one page of nent entries from the
//  RAM read port, absorbs the fixed RAM read latency, and presents the words as a valid/ready stream

---
 rtl/memory_page_reader_pkg.sv | 34 +++
 rtl/memory_page_reader_skid_fifo.sv | 79 +++++++
 rtl/memory_page_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/memory_page_reader_pkg.sv
// ----------------------------------------------------------------------------
// memory_page_reader_pkg
// Shared definitions for the paged block-RAM read master:
//   ENT_W        - width of the per-page entry index / entry count
//   PAGE_ENTRIES - maximum entries held by one page
//   state_t      - read master FSM encoding
//   clogb2       - ceil(log2(depth)), used to size addresses and counters
// ----------------------------------------------------------------------------
package memory_page_reader_pkg;

    localparam int ENT_W        = 5;
    localparam int PAGE_ENTRIES = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Number of bits needed to index 'depth' distinct locations.
    function automatic int clogb2(input int depth);
        int v;
        int r;
        v = depth - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_page_reader_skid_fifo.sv
// ----------------------------------------------------------------------------
// mem_rd_skid_fifo
// Small synchronous FIFO that absorbs RAM read data returning after the
// fixed read latency, so the downstream stream can stall freely.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_wr_en       - push i_wr_data (dropped if full and not popping)
//   i_wr_data     - data word to push
//   i_rd_en       - pop the head entry (ignored when empty)
//   o_rd_data     - head entry, stable until popped
//   o_valid       - FIFO holds at least one entry
//   o_count       - current number of stored entries
// ----------------------------------------------------------------------------
module mem_rd_skid_fifo
    import memory_page_reader_pkg::*;
#(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 3,
    localparam int CNT_W = clogb2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? clogb2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_rd;
    logic w_wr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_rd = i_rd_en && (r_count != '0);
    assign w_wr = i_wr_en && ((r_count != CNT_W'(DEPTH)) || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is only a few words and its head drives the
            // stream data port directly, so it is reset to give data_o = 0.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;

endmodule

// File: rtl/memory_page_reader.sv
// ----------------------------------------------------------------------------
// memory_page_reader
// Read-side master for the paged block-RAM store. A start pulse drains one
// page of nent entries through the RAM read port, absorbs the fixed RAM read
// latency and presents the words as a valid/ready stream with last marking.
// Ports:
//   clkb, rstb          - clock, asynchronous active-high reset
//   start/page_i/nent_i - request: page to drain and its entry count
//   addrb/enb/regceb    - RAM read port address, enable, output-reg enable
//   doutb               - RAM read data, valid RAM_LAT cycles after enb
//   data_o/valid_o/ready_i/last_o - output stream
//   busy, done          - request in progress, one-cycle completion pulse
// ----------------------------------------------------------------------------
module memory_page_reader
    import memory_page_reader_pkg::*;
#(
    parameter  int RAM_WIDTH = 18,
    parameter  int RAM_DEPTH = 1024,
    parameter  int PAGE_W    = 3,
    parameter  int RAM_LAT   = 2,
    localparam int ADDR_W    = clogb2(RAM_DEPTH)
) (
    input  logic                 clkb,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [PAGE_W-1:0]    page_i,
    input  logic [ENT_W-1:0]     nent_i,
    output logic [ADDR_W-1:0]    addrb,
    output logic                 enb,
    output logic                 regceb,
    input  logic [RAM_WIDTH-1:0] doutb,
    output logic [RAM_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 busy,
    output logic                 done
);

    localparam int FIFO_DEPTH = RAM_LAT + 1;
    localparam int CNT_W      = clogb2(FIFO_DEPTH + 1);
    // Wide enough for in-flight reads plus stored words.
    localparam int CR_W       = CNT_W + 1;

    state_t              r_state;
    logic [PAGE_W-1:0]   r_page;
    logic [ENT_W-1:0]    r_nent;
    logic [ENT_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_done;
    logic [RAM_LAT-1:0]  r_inflight;
    logic [RAM_LAT-1:0]  r_inflight_last;

    logic                w_pop;
    logic                w_fifo_valid;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [RAM_WIDTH:0]  w_fifo_rd_data;
    logic [CR_W-1:0]     w_inflight_cnt;
    logic [CR_W-1:0]     w_used;
    logic                w_issue;
    logic                w_issue_last;

    assign w_pop = w_fifo_valid && ready_i;

    // Credit check: reads already issued plus words stored, less the word
    // leaving this cycle, must leave room for one more read. Counting the
    // departing word (a combinational ready_i -> enb path) is what lets a
    // latency+1 deep FIFO sustain one beat per cycle.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        w_inflight_cnt = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + CR_W'(r_inflight[i]);
        end
        w_used  = w_inflight_cnt + CR_W'(w_fifo_count) - CR_W'(w_pop);
        w_issue = (r_state == ST_ISSUE) && (w_used < CR_W'(FIFO_DEPTH));
    end

    assign w_issue_last = (r_idx == (r_nent - ENT_W'(1)));

    // Read master FSM with registered busy/done.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            r_state <= ST_IDLE;
            r_page  <= '0;
            r_nent  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_page  <= page_i;
                        r_nent  <= nent_i;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (nent_i == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        if (w_issue_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // FIFO empty means the last beat has been accepted.
                    if ((r_inflight == '0) && (w_fifo_count == '0)) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // In-flight tracker: enb delayed by the RAM latency marks the cycle in
    // which doutb carries the matching word; the last tag travels alongside.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            r_inflight      <= '0;
            r_inflight_last <= '0;
        end else begin
            r_inflight[0]      <= w_issue;
            r_inflight_last[0] <= w_issue && w_issue_last;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_inflight[i]      <= r_inflight[i-1];
                r_inflight_last[i] <= r_inflight_last[i-1];
            end
        end
    end

    mem_rd_skid_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clkb),
        .rst       (rstb),
        .i_wr_en   (r_inflight[RAM_LAT-1]),
        .i_wr_data ({r_inflight_last[RAM_LAT-1], doutb}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    assign addrb   = ADDR_W'({r_page, r_idx});
    assign enb     = w_issue;
    assign regceb  = 1'b1;
    assign data_o  = w_fifo_rd_data[RAM_WIDTH-1:0];
    assign last_o  = w_fifo_rd_data[RAM_WIDTH];
    assign valid_o = w_fifo_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
